// File: rtl/simd_loop_pkg.sv
// Shared types and defaults for the SIMD loop controller.
package simd_loop_pkg;

  localparam int unsigned DEF_INST_WIDTH = 32;
  localparam int unsigned DEF_BODY_DEPTH = 16;
  localparam int unsigned DEF_ITER_BITS  = 16;

  // Value driven on err alongside the done pulse for a rejected configuration.
  localparam logic ERR_BAD_CFG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_REPLAY,
    ST_DONE
  } state_e;

endpackage

// File: rtl/simd_loop_ctrl_ram.sv
// Simple dual-port body RAM: one write port, one registered read port.
module ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    // Read data holds between reads so it can stand in as an issue register.
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/simd_loop_ctrl.sv
// Loop controller: passes instructions through, captures a loop body while
// issuing it, then replays the body from RAM until N iterations are issued.
module simd_loop_ctrl
  import simd_loop_pkg::*;
#(
  parameter int unsigned INST_WIDTH = DEF_INST_WIDTH,
  parameter int unsigned BODY_DEPTH = DEF_BODY_DEPTH,
  parameter int unsigned ITER_BITS  = DEF_ITER_BITS,
  localparam int unsigned AW = $clog2(BODY_DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ITER_BITS-1:0]  cfg_num_iters,
  input  logic [LW-1:0]         cfg_body_len,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  input  logic [INST_WIDTH-1:0] inst_data,
  input  logic                  issue_stall,
  output logic                  issue_valid,
  output logic [INST_WIDTH-1:0] issue_inst,
  output logic                  in_loop,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_e                r_state;
  logic [ITER_BITS-1:0]  r_num_iters;
  logic [LW-1:0]         r_len;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [ITER_BITS-1:0]  r_iter_cnt;
  logic                  r_issue_valid;
  logic [INST_WIDTH-1:0] r_issue_inst;
  logic                  r_in_loop;
  logic                  r_sel_ram;
  logic                  r_done;
  logic                  r_err;

  logic                  w_inst_ready;
  logic                  w_inst_acc;
  logic                  w_cfg_bad;
  logic [LW-1:0]         w_len_m1;
  logic                  w_fill_last;
  logic                  w_rd_last;
  logic                  w_iter_last;
  logic                  w_replay_step;
  logic [INST_WIDTH-1:0] w_ram_rdata;

  always_comb begin
    w_inst_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_inst_ready = !issue_stall && !cfg_valid;
      ST_FILL: w_inst_ready = !issue_stall;
      default: w_inst_ready = 1'b0;
    endcase
  end

  assign w_inst_acc    = inst_valid && w_inst_ready;
  assign w_cfg_bad     = (cfg_num_iters == '0) || (cfg_body_len == '0) ||
                         (cfg_body_len > LW'(BODY_DEPTH));
  assign w_len_m1      = r_len - LW'(1);
  assign w_fill_last   = ({1'b0, r_wr_ptr} == w_len_m1);
  assign w_rd_last     = ({1'b0, r_rd_ptr} == w_len_m1);
  assign w_iter_last   = (r_iter_cnt == (r_num_iters - ITER_BITS'(1)));
  assign w_replay_step = (r_state == ST_REPLAY) && !issue_stall;

  ram #(
    .DATA_WIDTH(INST_WIDTH),
    .ADDR_WIDTH(AW)
  ) u_body_ram (
    .clk     (clk),
    .i_we    ((r_state == ST_FILL) && w_inst_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (inst_data),
    .i_re    (w_replay_step),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_num_iters   <= '0;
      r_len         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_iter_cnt    <= '0;
      r_issue_valid <= 1'b0;
      r_issue_inst  <= '0;
      r_in_loop     <= 1'b0;
      r_sel_ram     <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_issue_valid <= 1'b0;
      r_in_loop     <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_valid) begin
            if (w_cfg_bad) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_err   <= ERR_BAD_CFG;
            end else begin
              r_num_iters <= cfg_num_iters;
              r_len       <= cfg_body_len;
              r_wr_ptr    <= '0;
              r_rd_ptr    <= '0;
              r_iter_cnt  <= '0;
              r_state     <= ST_FILL;
            end
          end else if (w_inst_acc) begin
            r_issue_valid <= 1'b1;
            r_issue_inst  <= inst_data;
            r_sel_ram     <= 1'b0;
          end
        end
        ST_FILL: begin
          if (w_inst_acc) begin
            r_issue_valid <= 1'b1;
            r_issue_inst  <= inst_data;
            r_in_loop     <= 1'b1;
            r_sel_ram     <= 1'b0;
            r_wr_ptr      <= r_wr_ptr + 1'b1;
            if (w_fill_last) begin
              if (r_num_iters == ITER_BITS'(1)) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state    <= ST_REPLAY;
                r_rd_ptr   <= '0;
                r_iter_cnt <= ITER_BITS'(1);
              end
            end
          end
        end
        ST_REPLAY: begin
          // Replay data arrives straight from the RAM read register.
          if (!issue_stall) begin
            r_issue_valid <= 1'b1;
            r_in_loop     <= 1'b1;
            r_sel_ram     <= 1'b1;
            if (w_rd_last) begin
              r_rd_ptr <= '0;
              if (w_iter_last) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_iter_cnt <= r_iter_cnt + 1'b1;
              end
            end else begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready   = (r_state == ST_IDLE);
  assign inst_ready  = w_inst_ready;
  assign issue_valid = r_issue_valid;
  assign issue_inst  = r_sel_ram ? w_ram_rdata : r_issue_inst;
  assign in_loop     = r_in_loop;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_simd_loop_ctrl.sv
// Directed bench for simd_loop_ctrl with an expected-issue queue model.
module tb_simd_loop_ctrl;

  localparam int unsigned IW = 32;
  localparam int unsigned BD = 16;
  localparam int unsigned IB = 16;
  localparam int unsigned LW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [IB-1:0] cfg_num_iters;
  logic [LW-1:0] cfg_body_len;
  logic          inst_valid;
  logic          inst_ready;
  logic [IW-1:0] inst_data;
  logic          issue_stall;
  logic          issue_valid;
  logic [IW-1:0] issue_inst;
  logic          in_loop;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  simd_loop_ctrl #(
    .INST_WIDTH(IW),
    .BODY_DEPTH(BD),
    .ITER_BITS (IB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_num_iters(cfg_num_iters),
    .cfg_body_len (cfg_body_len),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_data    (inst_data),
    .issue_stall  (issue_stall),
    .issue_valid  (issue_valid),
    .issue_inst   (issue_inst),
    .in_loop      (in_loop),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  typedef struct {
    logic [IW-1:0] inst;
    bit            in_loop;
    int            due;
  } exp_t;

  int unsigned   total = 0;
  int unsigned   bad   = 0;
  int            cyc   = 0;

  exp_t          exp_q[$];
  bit            exp_done[$];
  logic [IW-1:0] m_body[$];
  bit            m_filling = 1'b0;
  int unsigned   m_n = 0;
  int unsigned   m_l = 0;

  logic [IW-1:0] ilog[$];
  int            n_iss = 0;
  int            n_done = 0;
  int            first_iss = -1;
  int            last_iss = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected stream: every handshake-accepted instruction issues one cycle
  // later; a completed body fill queues (N-1) more copies of the body.
  task automatic cmp_step();
    exp_t e;
    if (reset) begin
      exp_q.delete();
      exp_done.delete();
      m_body.delete();
      m_filling = 1'b0;
    end else begin
      if (issue_valid) begin
        n_iss++;
        ilog.push_back(issue_inst);
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc;
        chk("issue_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("issue_inst", issue_inst, e.inst);
          chk("issue_in_loop", in_loop, e.in_loop);
          if (e.due >= 0) chk("issue_latency", cyc, e.due);
        end
      end
      if (done) begin
        n_done++;
        chk("done_expected", (exp_done.size() != 0), 1);
        if (exp_done.size() != 0) chk("done_err", err, exp_done.pop_front());
      end
      if (cfg_valid && cfg_ready) begin
        if (cfg_num_iters == 0 || cfg_body_len == 0 || cfg_body_len > BD) begin
          exp_done.push_back(1'b1);
        end else begin
          m_filling = 1'b1;
          m_n = cfg_num_iters;
          m_l = cfg_body_len;
          m_body.delete();
        end
      end else if (inst_valid && inst_ready) begin
        if (m_filling) begin
          exp_q.push_back('{inst: inst_data, in_loop: 1'b1, due: cyc + 1});
          m_body.push_back(inst_data);
          if (m_body.size() == m_l) begin
            for (int unsigned r = 1; r < m_n; r++)
              foreach (m_body[j]) exp_q.push_back('{inst: m_body[j], in_loop: 1'b1, due: -1});
            exp_done.push_back(1'b0);
            m_filling = 1'b0;
          end
        end else begin
          exp_q.push_back('{inst: inst_data, in_loop: 1'b0, due: cyc + 1});
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_inst(input logic [IW-1:0] d);
    int unsigned k = 0;
    inst_valid = 1'b1;
    inst_data  = d;
    #1;
    while (!inst_ready && k < 50) begin
      tick();
      k++;
    end
    chk("inst_accept", inst_ready, 1);
    tick();
    inst_valid = 1'b0;
  endtask

  task automatic send_cfg(input int unsigned n, input int unsigned l);
    int unsigned k = 0;
    cfg_valid     = 1'b1;
    cfg_num_iters = IB'(n);
    cfg_body_len  = LW'(l);
    #1;
    while (!cfg_ready && k < 50) begin
      tick();
      k++;
    end
    chk("cfg_accept", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    tick();
    while (busy && k < 300) begin
      tick();
      k++;
    end
    chk("wait_idle", busy, 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bd;
    int unsigned k;

    fork
      forever begin
        @(negedge clk);
        cmp_step();
      end
    join_none

    reset = 1'b1; cfg_valid = 1'b0; cfg_num_iters = '0; cfg_body_len = '0;
    inst_valid = 1'b0; inst_data = '0; issue_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_in_loop", in_loop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_issue_inst", issue_inst, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_inst_ready", inst_ready, 1);

    // Pass-through
    base = n_iss; ilog.delete();
    send_inst(32'hA1); send_inst(32'hA2); send_inst(32'hA3);
    tick();
    chk("pass_count", n_iss - base, 3);
    chk("pass_first", ilog[0], 32'hA1);
    chk("pass_last", ilog[2], 32'hA3);
    chk("pass_busy", busy, 0);

    // Basic loop N=3, L=4
    base = n_iss; bd = n_done; ilog.delete(); first_iss = -1;
    send_cfg(3, 4);
    for (int unsigned i = 0; i < 4; i++) send_inst(32'h100 + i);
    wait_idle();
    chk("loop_count", n_iss - base, 12);
    chk("loop_span", last_iss - first_iss, 11);
    chk("loop_done", n_done - bd, 1);
    chk("loop_log4", ilog[4], 32'h100);
    chk("loop_log6", ilog[6], 32'h102);
    chk("loop_log11", ilog[11], 32'h103);
    chk("loop_drained", exp_q.size(), 0);

    // Stall mid-replay N=2, L=2
    base = n_iss; ilog.delete(); first_iss = -1;
    send_cfg(2, 2);
    send_inst(32'h200); send_inst(32'h201);
    tick();
    issue_stall = 1'b1;
    #1;
    chk("replay_inst_ready", inst_ready, 0);
    chk("replay_busy", busy, 1);
    tick(); tick();
    chk("stall_no_issue", issue_valid, 0);
    tick();
    issue_stall = 1'b0;
    wait_idle();
    chk("stall_count", n_iss - base, 4);
    chk("stall_span", last_iss - first_iss, 6);
    chk("stall_log2", ilog[2], 32'h200);
    chk("stall_log3", ilog[3], 32'h201);

    // Bad configurations, then a minimal good loop
    base = n_iss; bd = n_done; ilog.delete();
    send_cfg(0, 4);
    chk("err_done", done, 1);
    chk("err_err", err, 1);
    chk("err_cfg_ready", cfg_ready, 0);
    chk("err_inst_ready", inst_ready, 0);
    wait_idle();
    send_cfg(5, 17);
    chk("err17_err", err, 1);
    wait_idle();
    send_cfg(2, 0);
    wait_idle();
    send_cfg(1, 1);
    send_inst(32'h300);
    wait_idle();
    chk("err_issues", n_iss - base, 1);
    chk("err_dones", n_done - bd, 4);
    chk("err_good_inst", ilog[0], 32'h300);

    // Collision: configuration wins, instruction becomes body element 0
    base = n_iss; ilog.delete();
    cfg_valid = 1'b1; cfg_num_iters = IB'(2); cfg_body_len = LW'(1);
    inst_valid = 1'b1; inst_data = 32'hC0;
    #1;
    chk("coll_inst_ready", inst_ready, 0);
    chk("coll_cfg_ready", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    send_inst(32'hC0);
    wait_idle();
    chk("coll_count", n_iss - base, 2);
    chk("coll_log0", ilog[0], 32'hC0);
    chk("coll_log1", ilog[1], 32'hC0);

    // Reset during replay of N=4, L=4
    base = n_iss; bd = n_done;
    send_cfg(4, 4);
    for (int unsigned i = 0; i < 4; i++) send_inst(32'h400 + i);
    k = 0;
    while ((n_iss - base) < 9 && k < 100) begin
      tick();
      k++;
    end
    chk("rst_reach_replay", ((n_iss - base) >= 9), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_issue_valid", issue_valid, 0);
    chk("abort_issue_inst", issue_inst, 0);
    chk("abort_cfg_ready", cfg_ready, 1);
    tick(); tick();
    chk("abort_no_done", n_done - bd, 0);
    base = n_iss; ilog.delete();
    send_inst(32'hE0);
    tick();
    chk("abort_pass_count", n_iss - base, 1);
    chk("abort_pass_inst", ilog[0], 32'hE0);
    chk("final_drained", exp_q.size() + exp_done.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simd_loop_ctrl.md
SIMD_LOOP_CTRL -- requirements
Module: simd_loop_ctrl

Interface
REQ-001 Parameter INST_WIDTH, default 32: width of one SIMD instruction word.
REQ-002 Parameter BODY_DEPTH, default 16: maximum loop-body instructions held for replay.
REQ-003 Parameter ITER_BITS, default 16: width of the loop iteration count.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cfg_valid / cfg_ready  in / out  1 / 1  loop-configuration handshake.
REQ-007 cfg_num_iters  in  ITER_BITS  total iterations N.
REQ-008 cfg_body_len  in  log2(BODY_DEPTH)+1  body length L in instructions.
REQ-009 inst_valid / inst_ready  in / out  1 / 1  incoming instruction handshake.
REQ-010 inst_data  in  INST_WIDTH  incoming instruction.
REQ-011 issue_stall  in  1  downstream back-pressure; no new issue while high.
REQ-012 issue_valid  out  1  one-cycle pulse per issued instruction.
REQ-013 issue_inst  out  INST_WIDTH  issued instruction, valid with issue_valid.
REQ-014 in_loop  out  1  qualifies issue_valid; high for loop-body issues, drives the iterator in_loop input.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done / err  out  1 / 1  one-cycle completion pulse; err is valid only with done.

Function
REQ-017 States: IDLE, FILL, REPLAY, DONE.
REQ-018 IDLE: cfg_ready=1; inst_ready=!issue_stall && !cfg_valid; each accepted instruction issues with in_loop=0.
REQ-019 IDLE with cfg_valid and inst_valid in the same cycle: accept the configuration only; the instruction waits.
REQ-020 Configuration accept with N=0, L=0 or L>BODY_DEPTH: go to DONE; err=1 on the done pulse; nothing is issued.
REQ-021 Any other configuration accept: latch N and L, clear wr_ptr and iter_cnt, go to FILL.
REQ-022 FILL: cfg_ready=0; inst_ready=!issue_stall.
REQ-023 FILL, per accepted instruction: write it to buffer[wr_ptr] and issue it with in_loop=1 (iteration 1).
REQ-024 FILL, after accepting instruction L: if N=1 go to DONE, else go to REPLAY with rd_ptr=0 and iter_cnt=1.
REQ-025 REPLAY: inst_ready=0; issue buffer[rd_ptr] with in_loop=1 in each cycle where issue_stall=0; rd_ptr wraps L-1 to 0 and iter_cnt increments.
REQ-026 REPLAY: when iter_cnt reaches N-1 and rd_ptr reaches L-1, issue the final instruction and go to DONE.
REQ-027 issue_stall=1 in REPLAY: rd_ptr, iter_cnt and the buffer read hold; no issue_valid; replay resumes at the same instruction.
REQ-028 Issue latency: exactly 1 cycle from an accepted handshake, or from the replay read cycle, to issue_valid.
REQ-029 Issue outputs come from registers; issue_inst holds its last value when issue_valid=0.
REQ-030 DONE: done=1 for one cycle, then go to IDLE; cfg_ready=inst_ready=0 while in DONE.
REQ-031 Total loop issues equal exactly N*L; with no stall they arrive back-to-back, one per cycle.
REQ-032 iter_cnt is ITER_BITS wide and never wraps: N=2^ITER_BITS-1 completes normally.

Reset
REQ-033 Reset puts the block in IDLE, clears all pointers and counters, and drives issue_valid, in_loop, busy, done and err low; issue_inst=0.
REQ-034 Reset mid-FILL or mid-REPLAY aborts the loop; no done pulse; buffer contents become don't-care.

Structure
REQ-035 Shared package simd_loop_pkg holds the state enum, default INST_WIDTH, BODY_DEPTH and ITER_BITS, and the error code.
REQ-036 The body buffer is one instance of the existing ram sub-module: DATA_WIDTH=INST_WIDTH, ADDR_WIDTH=log2(BODY_DEPTH), 1-cycle read.
REQ-037 Everything else (FSM, counters, issue registers) is flat in simd_loop_ctrl.

Verification
REQ-038 Pass-through: IDLE, 3 instructions, no stall -> 3 issue_valid pulses with in_loop=0, each 1 cycle after acceptance, in order.
REQ-039 Basic loop: N=3, L=4, no stall -> 12 consecutive issues in order A,B,C,D repeated 3 times, in_loop=1 throughout, then done=1 and err=0.
REQ-040 Stall: N=2, L=2, issue_stall high for 3 cycles mid-REPLAY -> no issue during the stall, sequence A,B,A,B preserved, 4 issues total.
REQ-041 Errors: cfg N=0 -> done=1, err=1, 0 issues; cfg L=17 -> done=1, err=1; then a valid cfg N=1, L=1 -> 1 issue, done=1, err=0.
REQ-042 Collision: cfg_valid and inst_valid together in IDLE -> cfg accepted, inst_ready=0 that cycle, the instruction becomes body element 0.
REQ-043 Reset at the 5th REPLAY issue of N=4, L=4 -> next cycle: IDLE, busy=0, no done; a following pass-through instruction issues with in_loop=0.
